// File: rtl/circle_plotter.sv
// Midpoint circle rasteriser for the 160x120 VGA plot path: one octant pixel per cycle, off-screen pixels suppressed.
// Define CIRCLE_FILL_EN to draw a filled disc with horizontal spans instead of the outline.
module circle_plotter #(
  parameter int X_W      = 8,
  parameter int Y_W      = 7,
  parameter int R_W      = 6,
  parameter int COLOUR_W = 3,
  parameter int SCREEN_W = 160,
  parameter int SCREEN_H = 120
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                start,
  input  logic [X_W-1:0]      cx,
  input  logic [Y_W-1:0]      cy,
  input  logic [R_W-1:0]      radius,
  input  logic [COLOUR_W-1:0] colour,
  output logic                busy,
  output logic                done,
  output logic [X_W-1:0]      vga_x,
  output logic [Y_W-1:0]      vga_y,
  output logic [COLOUR_W-1:0] vga_colour,
  output logic                vga_plot
);

`ifdef CIRCLE_FILL_EN
  typedef enum logic [3:0] {IDLE, INIT, S1, S2, S3, S4, DONE} state_t;
`else
  typedef enum logic [3:0] {IDLE, INIT, P1, P2, P3, P4, P5, P6, P7, P8, DONE} state_t;
`endif

  localparam logic signed [R_W+1:0] D_ONE = (R_W+2)'(1);
  localparam logic signed [X_W:0]   SW    = (X_W+1)'(SCREEN_W);
  localparam logic signed [Y_W:0]   SH    = (Y_W+1)'(SCREEN_H);

  state_t state;
  logic [X_W-1:0]      lcx;
  logic [Y_W-1:0]      lcy;
  logic [R_W-1:0]      lrad;
  logic [COLOUR_W-1:0] lcol;
  logic signed [R_W+1:0] ox, oy, d;

  logic signed [R_W+1:0] rad_s, oy_n, ox_n, d_n;
  logic signed [X_W:0]   cxs, ox_x, oy_x, px;
  logic signed [Y_W:0]   cys, ox_y, oy_y, py;
  logic                  plotting, in_screen, last;

`ifdef CIRCLE_FILL_EN
  localparam logic signed [X_W:0] SPAN_ONE = (X_W+1)'(1);
  logic signed [X_W:0] span_x, span_end;
`endif

  assign rad_s = $signed({2'b00, lrad});
  assign cxs   = $signed({1'b0, lcx});
  assign cys   = $signed({1'b0, lcy});
  assign ox_x  = (X_W+1)'(ox);
  assign oy_x  = (X_W+1)'(oy);
  assign ox_y  = (Y_W+1)'(ox);
  assign oy_y  = (Y_W+1)'(oy);

  // Midpoint step taken once all pixels of the current (ox, oy) pair are out.
  always_comb begin
    oy_n = oy + D_ONE;
    ox_n = ox;
    d_n  = d + (oy_n <<< 1) + D_ONE;
    if (!(d[R_W+1] || d == '0)) begin
      ox_n = ox - D_ONE;
      d_n  = d + ((oy_n - ox_n) <<< 1) + D_ONE;
    end
    last = oy_n > ox_n;
  end

  always_comb begin
    px       = '0;
    py       = '0;
    plotting = 1'b1;
`ifdef CIRCLE_FILL_EN
    span_end = cxs + ox_x;
    case (state)
      S1: begin px = span_x; py = cys + oy_y; end
      S2: begin px = span_x; py = cys - oy_y; end
      S3: begin px = span_x; py = cys + ox_y; span_end = cxs + oy_x; end
      S4: begin px = span_x; py = cys - ox_y; span_end = cxs + oy_x; end
      default: plotting = 1'b0;
    endcase
`else
    case (state)
      P1: begin px = cxs + ox_x; py = cys + oy_y; end
      P2: begin px = cxs + oy_x; py = cys + ox_y; end
      P3: begin px = cxs - oy_x; py = cys + ox_y; end
      P4: begin px = cxs - ox_x; py = cys + oy_y; end
      P5: begin px = cxs - ox_x; py = cys - oy_y; end
      P6: begin px = cxs - oy_x; py = cys - ox_y; end
      P7: begin px = cxs + oy_x; py = cys - ox_y; end
      P8: begin px = cxs + ox_x; py = cys - oy_y; end
      default: plotting = 1'b0;
    endcase
`endif
    in_screen = !px[X_W] && (px < SW) && !py[Y_W] && (py < SH);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= IDLE;
      lcx        <= '0;
      lcy        <= '0;
      lrad       <= '0;
      lcol       <= '0;
      ox         <= '0;
      oy         <= '0;
      d          <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      vga_x      <= '0;
      vga_y      <= '0;
      vga_colour <= '0;
      vga_plot   <= 1'b0;
`ifdef CIRCLE_FILL_EN
      span_x     <= '0;
`endif
    end else begin
      done     <= 1'b0;
      vga_plot <= 1'b0;
      // The pixel chosen in this state is presented on the following cycle.
      if (plotting) begin
        vga_x      <= px[X_W-1:0];
        vga_y      <= py[Y_W-1:0];
        vga_colour <= lcol;
        vga_plot   <= in_screen;
      end
      case (state)
        IDLE: begin
          busy <= start;
          if (start) begin
            lcx   <= cx;
            lcy   <= cy;
            lrad  <= radius;
            lcol  <= colour;
            state <= INIT;
          end
        end
        INIT: begin
          ox <= rad_s;
          oy <= '0;
          d  <= D_ONE - rad_s;
`ifdef CIRCLE_FILL_EN
          span_x <= cxs - (X_W+1)'(rad_s);
          state  <= S1;
`else
          state  <= P1;
`endif
        end
`ifdef CIRCLE_FILL_EN
        S1, S2, S3: begin
          if (span_x == span_end) begin
            span_x <= (state == S1) ? cxs - ox_x : cxs - oy_x;
            state  <= (state == S1) ? S2 : (state == S2) ? S3 : S4;
          end else begin
            span_x <= span_x + SPAN_ONE;
          end
        end
        S4: begin
          if (span_x == span_end) begin
            ox     <= ox_n;
            oy     <= oy_n;
            d      <= d_n;
            span_x <= cxs - (X_W+1)'(ox_n);
            state  <= last ? DONE : S1;
          end else begin
            span_x <= span_x + SPAN_ONE;
          end
        end
`else
        P1: state <= P2;
        P2: state <= P3;
        P3: state <= P4;
        P4: state <= P5;
        P5: state <= P6;
        P6: state <= P7;
        P7: state <= P8;
        P8: begin
          ox    <= ox_n;
          oy    <= oy_n;
          d     <= d_n;
          state <= last ? DONE : P1;
        end
`endif
        DONE: begin
          done  <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
